// File: rtl/i2c_master_rd.sv
// I2C master receiver: START, 7- or 10-bit address phase, 1..8 data bytes, STOP.
// Every bit slot is four quarter-period ticks from the shared SCL-rate tick.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | bus released, waiting for a start edge while enabled
// START   | START condition (SDA falls while SCL high)
// ADDR    | shifting an address byte out MSB first
// AACK    | SDA released, slave ACK sampled in Q2
// RSTART  | repeated START between 10-bit address low byte and read header
// DATA    | SDA released, 8 data bits sampled MSB first
// MACK    | master ACK (more bytes wanted) or NACK (last byte)
// STOP    | STOP condition (SDA rises while SCL high)
// DONE    | one-cycle completion strobe
module i2c_master_rd #(
    parameter int MAX_BYTES = 8
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_clk_i2ctick,
    input  logic                   i_i2c_en,
    input  logic                   i_i2c_start,
    input  logic [1:0]             i_len_add,
    input  logic [2:0]             i_num_by,
    input  logic [9:0]             i_add_sla,
    input  logic                   i_sda,
    output logic                   o_scl,
    output logic                   o_sda_oe,
    output logic [8*MAX_BYTES-1:0] o_data_rx,
    output logic                   o_detect,
    output logic                   o_rxe,
    output logic                   o_rxne,
    output logic                   o_busy,
    output logic                   o_rs,
    output logic                   o_err
);

    localparam logic [3:0] ST_IDLE   = 4'd0;
    localparam logic [3:0] ST_START  = 4'd1;
    localparam logic [3:0] ST_ADDR   = 4'd2;
    localparam logic [3:0] ST_AACK   = 4'd3;
    localparam logic [3:0] ST_RSTART = 4'd4;
    localparam logic [3:0] ST_DATA   = 4'd5;
    localparam logic [3:0] ST_MACK   = 4'd6;
    localparam logic [3:0] ST_STOP   = 4'd7;
    localparam logic [3:0] ST_DONE   = 4'd8;

    // addr_step: 0 = first 10-bit header, 1 = 10-bit low byte, 2 = final (read) header
    logic [3:0] state;
    logic [1:0] qtr;
    logic [2:0] bit_cnt;
    logic [7:0] tx_byte;
    logic [7:0] rx_shift;
    logic [2:0] byte_idx;
    logic [2:0] num_by_q;
    logic [9:0] addr_q;
    logic [1:0] addr_step;
    logic       ack_bit;
    logic       start_q;
    logic       start_edge;
    logic       scl_pulse;

    assign start_edge = i_i2c_start & ~start_q;
    assign scl_pulse  = (qtr == 2'd1) || (qtr == 2'd2);
    assign o_rs       = (state == ST_DONE);
    assign o_rxe      = ~o_rxne;

    // Transaction sequencing: launch, tick-driven slot progress, abort on enable loss
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state     <= ST_IDLE;
            qtr       <= 2'd0;
            bit_cnt   <= 3'd0;
            tx_byte   <= 8'd0;
            rx_shift  <= 8'd0;
            byte_idx  <= 3'd0;
            num_by_q  <= 3'd0;
            addr_q    <= 10'd0;
            addr_step <= 2'd0;
            ack_bit   <= 1'b0;
            start_q   <= 1'b0;
            o_data_rx <= '0;
            o_detect  <= 1'b0;
            o_rxne    <= 1'b0;
            o_busy    <= 1'b0;
            o_err     <= 1'b0;
        end else begin
            start_q <= i_i2c_start;
            if (state == ST_IDLE) begin
                if (start_edge && i_i2c_en) begin
                    state     <= ST_START;
                    qtr       <= 2'd0;
                    byte_idx  <= 3'd0;
                    num_by_q  <= i_num_by;
                    addr_q    <= i_add_sla;
                    o_data_rx <= '0;
                    o_detect  <= 1'b0;
                    o_rxne    <= 1'b0;
                    o_err     <= 1'b0;
                    o_busy    <= 1'b1;
                    if (i_len_add == 2'b01) begin
                        tx_byte   <= {5'b11110, i_add_sla[9:8], 1'b0};
                        addr_step <= 2'd0;
                    end else begin
                        tx_byte   <= {i_add_sla[6:0], 1'b1};
                        addr_step <= 2'd2;
                    end
                end
            end else if (state == ST_DONE) begin
                state <= ST_IDLE;
            end else if (!i_i2c_en) begin
                state  <= ST_IDLE;
                qtr    <= 2'd0;
                o_busy <= 1'b0;
                o_err  <= 1'b1;
            end else if (i_clk_i2ctick) begin
                qtr <= qtr + 2'd1;
                case (state)
                    ST_START: begin
                        if (qtr == 2'd3) begin
                            state   <= ST_ADDR;
                            bit_cnt <= 3'd7;
                        end
                    end
                    ST_ADDR: begin
                        if (qtr == 2'd3) begin
                            if (bit_cnt == 3'd0) begin
                                state <= ST_AACK;
                            end else begin
                                bit_cnt <= bit_cnt - 3'd1;
                                tx_byte <= {tx_byte[6:0], 1'b0};
                            end
                        end
                    end
                    ST_AACK: begin
                        if (qtr == 2'd2) ack_bit <= i_sda;
                        if (qtr == 2'd3) begin
                            if (ack_bit) begin
                                o_err <= 1'b1;
                                state <= ST_STOP;
                            end else begin
                                case (addr_step)
                                    2'd0: begin
                                        tx_byte   <= addr_q[7:0];
                                        addr_step <= 2'd1;
                                        bit_cnt   <= 3'd7;
                                        state     <= ST_ADDR;
                                    end
                                    2'd1: state <= ST_RSTART;
                                    default: begin
                                        o_detect <= 1'b1;
                                        bit_cnt  <= 3'd7;
                                        byte_idx <= 3'd0;
                                        state    <= ST_DATA;
                                    end
                                endcase
                            end
                        end
                    end
                    ST_RSTART: begin
                        if (qtr == 2'd3) begin
                            tx_byte   <= {5'b11110, addr_q[9:8], 1'b1};
                            addr_step <= 2'd2;
                            bit_cnt   <= 3'd7;
                            state     <= ST_ADDR;
                        end
                    end
                    ST_DATA: begin
                        if (qtr == 2'd2) rx_shift <= {rx_shift[6:0], i_sda};
                        if (qtr == 2'd3) begin
                            if (bit_cnt == 3'd0) begin
                                if (int'(byte_idx) < MAX_BYTES)
                                    o_data_rx[{byte_idx, 3'b000} +: 8] <= rx_shift;
                                state <= ST_MACK;
                            end else begin
                                bit_cnt <= bit_cnt - 3'd1;
                            end
                        end
                    end
                    ST_MACK: begin
                        if (qtr == 2'd3) begin
                            if (byte_idx == num_by_q) begin
                                state <= ST_STOP;
                            end else begin
                                byte_idx <= byte_idx + 3'd1;
                                bit_cnt  <= 3'd7;
                                state    <= ST_DATA;
                            end
                        end
                    end
                    ST_STOP: begin
                        if (qtr == 2'd3) begin
                            o_busy <= 1'b0;
                            if (o_err) begin
                                state <= ST_IDLE;
                            end else begin
                                o_rxne <= 1'b1;
                                state  <= ST_DONE;
                            end
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    // Bus drive levels per state and quarter; SDA only changes while SCL is low
    // except for the START/RSTART/STOP conditions
    always_comb begin
        o_scl    = 1'b1;
        o_sda_oe = 1'b0;
        case (state)
            ST_START: begin
                o_scl    = (qtr != 2'd3);
                o_sda_oe = (qtr != 2'd0);
            end
            ST_ADDR: begin
                o_scl    = scl_pulse;
                o_sda_oe = ~tx_byte[7];
            end
            ST_AACK, ST_DATA: begin
                o_scl = scl_pulse;
            end
            ST_MACK: begin
                o_scl    = scl_pulse;
                o_sda_oe = (byte_idx != num_by_q);
            end
            ST_RSTART: begin
                o_scl    = scl_pulse;
                o_sda_oe = qtr[1];
            end
            ST_STOP: begin
                o_scl    = (qtr != 2'd0);
                o_sda_oe = ~qtr[1];
            end
            default: begin
                o_scl    = 1'b1;
                o_sda_oe = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_i2c_master_rd.sv
// Bench for i2c_master_rd: a slot-level bus model produces the expected SCL/SDA
// drive per quarter tick plus the slave responses, and the final status/data.
module tb_i2c_master_rd;

    logic        clk = 1'b0;
    logic        i_rst_n;
    logic        i_clk_i2ctick;
    logic        i_i2c_en;
    logic        i_i2c_start;
    logic [1:0]  i_len_add;
    logic [2:0]  i_num_by;
    logic [9:0]  i_add_sla;
    logic        i_sda;
    logic        o_scl;
    logic        o_sda_oe;
    logic [63:0] o_data_rx;
    logic        o_detect;
    logic        o_rxe;
    logic        o_rxne;
    logic        o_busy;
    logic        o_rs;
    logic        o_err;

    logic        slave_drv = 1'b1;
    assign i_sda = slave_drv & ~o_sda_oe;

    always #5 clk = ~clk;

    i2c_master_rd #(.MAX_BYTES(8)) dut (
        .i_clk         (clk),
        .i_rst_n       (i_rst_n),
        .i_clk_i2ctick (i_clk_i2ctick),
        .i_i2c_en      (i_i2c_en),
        .i_i2c_start   (i_i2c_start),
        .i_len_add     (i_len_add),
        .i_num_by      (i_num_by),
        .i_add_sla     (i_add_sla),
        .i_sda         (i_sda),
        .o_scl         (o_scl),
        .o_sda_oe      (o_sda_oe),
        .o_data_rx     (o_data_rx),
        .o_detect      (o_detect),
        .o_rxe         (o_rxe),
        .o_rxne        (o_rxne),
        .o_busy        (o_busy),
        .o_rs          (o_rs),
        .o_err         (o_err)
    );

    int total = 0;
    int bad   = 0;

    // expected bus activity, one entry per quarter tick
    bit       exp_scl [0:511];
    bit       exp_oe  [0:511];
    bit       slv     [0:511];
    int       nq;
    int       store_q [8];
    bit       exp_nack;
    bit [7:0] td [8];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, " scl"}, o_scl, 1);
        chk({tag, " sda_oe"}, o_sda_oe, 0);
        chk({tag, " data"}, o_data_rx, 0);
        chk({tag, " detect"}, o_detect, 0);
        chk({tag, " rxe"}, o_rxe, 1);
        chk({tag, " rxne"}, o_rxne, 0);
        chk({tag, " busy"}, o_busy, 0);
        chk({tag, " rs"}, o_rs, 0);
        chk({tag, " err"}, o_err, 0);
    endtask

    // one bus slot = 4 quarters; patterns written q0..q3 left to right
    task automatic add_slot(input bit [3:0] s, input bit [3:0] o, input bit d);
        for (int i = 0; i < 4; i++) begin
            exp_scl[nq] = s[3-i];
            exp_oe[nq]  = o[3-i];
            slv[nq]     = d;
            nq++;
        end
    endtask

    task automatic build(input bit ten, input bit [9:0] a, input int nb, input bit [2:0] nack_mask);
        bit [7:0] ab;
        bit       ackb;
        int       na;
        nq = 0;
        exp_nack = 0;
        for (int k = 0; k < 8; k++) store_q[k] = 1 << 20;
        add_slot(4'b1110, 4'b0111, 1'b1);
        na = ten ? 3 : 1;
        for (int j = 0; j < na; j++) begin
            if (!ten) ab = {a[6:0], 1'b1};
            else if (j == 0) ab = {5'b11110, a[9:8], 1'b0};
            else if (j == 1) ab = a[7:0];
            else begin
                add_slot(4'b0110, 4'b0011, 1'b1);
                ab = {5'b11110, a[9:8], 1'b1};
            end
            for (int b = 7; b >= 0; b--) add_slot(4'b0110, {4{~ab[b]}}, 1'b1);
            add_slot(4'b0110, 4'b0000, nack_mask[j]);
            if (nack_mask[j]) begin
                exp_nack = 1;
                add_slot(4'b0111, 4'b1100, 1'b1);
                return;
            end
        end
        for (int k = 0; k <= nb; k++) begin
            for (int b = 7; b >= 0; b--) add_slot(4'b0110, 4'b0000, td[k][b]);
            store_q[k] = nq - 1;
            ackb = (k < nb);
            add_slot(4'b0110, {4{ackb}}, 1'b1);
        end
        add_slot(4'b0111, 4'b1100, 1'b1);
    endtask

    task automatic run_txn(input bit [1:0] len, input bit [9:0] a, input int nb,
                           input bit [2:0] nack_mask, input int abort_q,
                           input int glitch_q, input int rst_q);
        bit          ten;
        logic [63:0] exp_data;
        ten = (len == 2'b01);
        build(ten, a, nb, nack_mask);
        @(negedge clk);
        i_len_add     = len;
        i_add_sla     = a;
        i_num_by      = nb[2:0];
        i_i2c_start   = 1'b1;
        i_clk_i2ctick = 1'($urandom_range(0, 1));
        @(negedge clk);
        i_i2c_start   = 1'b0;
        i_clk_i2ctick = 1'b0;
        i_num_by      = 3'($urandom);
        i_add_sla     = 10'($urandom);
        i_len_add     = 2'($urandom);
        chk("launch busy", o_busy, 1);
        chk("launch err", o_err, 0);
        chk("launch rxne", o_rxne, 0);
        chk("launch rxe", o_rxe, 1);
        chk("launch detect", o_detect, 0);
        chk("launch data", o_data_rx, 0);
        for (int q = 0; q < nq; q++) begin
            slave_drv = slv[q];
            chk($sformatf("scl q%0d", q), o_scl, exp_scl[q]);
            chk($sformatf("sda_oe q%0d", q), o_sda_oe, exp_oe[q]);
            chk($sformatf("busy q%0d", q), o_busy, 1);
            chk($sformatf("rs q%0d", q), o_rs, 0);
            if (q == abort_q) begin
                i_i2c_en = 1'b0;
                @(negedge clk);
                i_i2c_en = 1'b1;
                exp_data = '0;
                for (int k = 0; k < 8; k++)
                    if (store_q[k] < abort_q) exp_data[8*k +: 8] = td[k];
                slave_drv = 1'b1;
                chk("abort busy", o_busy, 0);
                chk("abort err", o_err, 1);
                chk("abort scl", o_scl, 1);
                chk("abort sda_oe", o_sda_oe, 0);
                chk("abort rs", o_rs, 0);
                chk("abort rxne", o_rxne, 0);
                chk("abort data", o_data_rx, exp_data);
                return;
            end
            if (q == rst_q) begin
                i_rst_n = 1'b0;
                @(negedge clk);
                i_rst_n = 1'b1;
                slave_drv = 1'b1;
                chk_reset_vals("midreset");
                return;
            end
            if (q == glitch_q) begin
                i_i2c_start = 1'b1;
                @(negedge clk);
                i_i2c_start = 1'b0;
            end
            repeat ($urandom_range(0, 2)) @(negedge clk);
            i_clk_i2ctick = 1'b1;
            @(negedge clk);
            i_clk_i2ctick = 1'b0;
        end
        slave_drv = 1'b1;
        exp_data = '0;
        if (!exp_nack)
            for (int k = 0; k <= nb; k++) exp_data[8*k +: 8] = td[k];
        chk("end busy", o_busy, 0);
        chk("end rs", o_rs, !exp_nack);
        chk("end err", o_err, exp_nack);
        chk("end detect", o_detect, !exp_nack);
        chk("end rxne", o_rxne, !exp_nack);
        chk("end rxe", o_rxe, exp_nack);
        chk("end data", o_data_rx, exp_data);
        @(negedge clk);
        chk("post rs", o_rs, 0);
        chk("post busy", o_busy, 0);
        chk("post scl", o_scl, 1);
        chk("post sda_oe", o_sda_oe, 0);
    endtask

    initial begin
        i_rst_n       = 1'b0;
        i_clk_i2ctick = 1'b0;
        i_i2c_en      = 1'b1;
        i_i2c_start   = 1'b0;
        i_len_add     = 2'b00;
        i_num_by      = 3'd0;
        i_add_sla     = 10'd0;
        repeat (3) @(negedge clk);
        chk_reset_vals("reset");
        i_rst_n = 1'b1;
        @(negedge clk);

        // 7-bit 0x50, two bytes
        td[0] = 8'hA5; td[1] = 8'h3C;
        run_txn(2'b00, 10'h050, 1, 3'b000, -1, -1, -1);

        // 7-bit 0x3A, address NACK
        run_txn(2'b00, 10'h03A, 0, 3'b001, -1, -1, -1);

        // 10-bit 0x2C5, one byte
        td[0] = 8'h77;
        run_txn(2'b01, 10'h2C5, 0, 3'b000, -1, -1, -1);

        // eight bytes
        for (int k = 0; k < 8; k++) td[k] = 8'(k + 1);
        run_txn(2'b00, 10'h012, 7, 3'b000, -1, -1, -1);

        // 10-bit, NACK on the low address byte
        run_txn(2'b01, 10'h1F0, 3, 3'b010, -1, -1, -1);

        // enable dropped during data bit 3 of byte 0 (quarter 2 of the fourth bit slot)
        run_txn(2'b00, 10'h044, 2, 3'b000, 40 + 12 + 2, -1, -1);

        // enable dropped after two full bytes
        for (int k = 0; k < 8; k++) td[k] = 8'($urandom);
        run_txn(2'b00, 10'h021, 5, 3'b000, 40 + 2 * 36 + 5, -1, -1);

        // start edge while busy is ignored
        run_txn(2'b00, 10'h05A, 1, 3'b000, -1, 70, -1);

        // reset mid-DATA, then a clean transaction
        run_txn(2'b00, 10'h033, 1, 3'b000, -1, -1, 40 + 9);
        td[0] = 8'hC3; td[1] = 8'h5E;
        run_txn(2'b00, 10'h033, 1, 3'b000, -1, -1, -1);

        // no launch while disabled
        @(negedge clk);
        i_i2c_en = 1'b0;
        i_i2c_start = 1'b1;
        @(negedge clk);
        i_i2c_start = 1'b0;
        @(negedge clk);
        chk("disabled busy", o_busy, 0);
        chk("disabled scl", o_scl, 1);
        i_i2c_en = 1'b1;
        @(negedge clk);

        // randomized transactions
        for (int t = 0; t < 12; t++) begin
            bit [2:0] nm;
            for (int k = 0; k < 8; k++) td[k] = 8'($urandom);
            nm = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
            run_txn(2'($urandom), 10'($urandom), $urandom_range(0, 7), nm, -1,
                    ($urandom_range(0, 1) == 1) ? $urandom_range(0, 60) : -1, -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
